// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the RV32I instruction-fetch stage.
//
// Contents:
//   S_BOOT..S_FAULT : fetch FSM state encodings (2-bit, legacy-compatible)
//   NOP_INSTR       : canonical RV32I NOP (addi x0, x0, 0)
//   INSTR_BYTES     : PC increment per fetched instruction
//   isAligned()     : true when a byte address is word aligned
//
// Optional feature macro used by this slice: FETCH_PERF_EN (see fetch_unit.sv).

package riscv_fetch_pkg;

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_END   = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam logic [31:0] INSTR_BYTES = 32'd4;

    // Only the two low address bits matter for word alignment.
    function automatic logic isAligned(input logic [1:0] lowBits);
        return (lowBits == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch stage, instruction memory, execute (redirects)
// and decode (IF/ID handshake).
//
// Signals:
//   imem_pc        fetch -> imem    byte address (combinational read)
//   imem_instr     imem  -> fetch   word at imem_pc, same cycle
//   redirect_valid execute -> fetch taken branch/jump
//   redirect_pc    execute -> fetch redirect target byte address
//   id_ready       decode -> fetch  decode accepts id_instr this cycle
//   id_valid       fetch -> decode  id_instr/id_pc hold a valid instruction
//   id_instr       fetch -> decode  fetched instruction word
//   id_pc          fetch -> decode  address of id_instr
//
// Modports: master = the fetch stage, slave = its environment.

interface fetch_unit_if;

    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    modport master (
        output imem_pc,
        input  imem_instr,
        input  redirect_valid,
        input  redirect_pc,
        input  id_ready,
        output id_valid,
        output id_instr,
        output id_pc
    );

    modport slave (
        input  imem_pc,
        output imem_instr,
        output redirect_valid,
        output redirect_pc,
        output id_ready,
        input  id_valid,
        input  id_instr,
        input  id_pc
    );

endinterface

// File: rtl/fetch_unit_ifid_reg.sv
// IF/ID pipeline register: valid bit plus instruction word and its PC.
//
// Ports:
//   clock, reset   core clock; synchronous active-low reset
//   load_i         capture instr_i/pc_i and set valid
//   flush_i        clear valid (highest priority)
//   drain_i        clear valid when decode consumed the entry and nothing new loads
//   instr_i, pc_i  incoming instruction word and its address
//   valid_o, instr_o, pc_o  registered IF/ID contents

module ifid_reg
    import riscv_fetch_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load_i,
    input  logic        flush_i,
    input  logic        drain_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o
);

    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] pc_q;

    // Flush beats load so a redirect discards a word fetched in the same cycle;
    // with no control active the entry holds, which is how decode stalls work.
    always_ff @(posedge clock) begin
        if (!reset) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc_q    <= 32'd0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end else if (drain_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage of the single-issue RV32I core.
//
// Drives the instruction-memory PC, captures the returned word into the IF/ID
// register and hands it to decode over a valid/ready handshake. Handles
// redirects, decode stalls, end-of-program and misaligned-redirect faults.
//
// Ports:
//   clock        core clock, all state updates on posedge
//   reset        synchronous, active-low reset
//   bus          fetch_unit_if.master (imem, redirect and IF/ID handshake)
//   prog_done    PC reached PC_LIMIT; no further fetches
//   fetch_fault  sticky; a redirect target was misaligned
//   perf_fetch_cnt, perf_stall_cnt  (only with FETCH_PERF_EN) saturating counters
//
// Parameters: RESET_PC (first fetch address), PC_LIMIT (first address past program).
// Optional feature macro: FETCH_PERF_EN.

module fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0004,
    parameter logic [31:0] PC_LIMIT = 32'd28
) (
    input  logic         clock,
    input  logic         reset,
    fetch_unit_if.master bus,
    output logic         prog_done,
    output logic         fetch_fault
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]  perf_fetch_cnt,
    output logic [31:0]  perf_stall_cnt
`endif
);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        loadIfid;
    logic        flushIfid;
    logic        drainIfid;
    logic        idValid;

    // Next-state logic. Redirects win over everything in RUN/END; a misaligned
    // target leaves the PC untouched and parks the FSM in FAULT. Reaching the
    // limit stops fetching but lets the last IF/ID entry drain normally.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        loadIfid  = 1'b0;
        flushIfid = 1'b0;
        drainIfid = 1'b0;
        case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
            end
            S_RUN, S_END: begin
                if (bus.redirect_valid) begin
                    flushIfid = 1'b1;
                    if (!isAligned(bus.redirect_pc[1:0])) begin
                        state_d = S_FAULT;
                    end else begin
                        pc_d    = bus.redirect_pc;
                        state_d = (bus.redirect_pc < PC_LIMIT) ? S_RUN : S_END;
                    end
                end else if (state_q == S_END || pc_q >= PC_LIMIT) begin
                    state_d   = S_END;
                    drainIfid = bus.id_ready;
                end else if (!idValid || bus.id_ready) begin
                    loadIfid = 1'b1;
                    pc_d     = pc_q + INSTR_BYTES;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    ifid_reg u_ifid (
        .clock   (clock),
        .reset   (reset),
        .load_i  (loadIfid),
        .flush_i (flushIfid),
        .drain_i (drainIfid),
        .instr_i (bus.imem_instr),
        .pc_i    (pc_q),
        .valid_o (idValid),
        .instr_o (bus.id_instr),
        .pc_o    (bus.id_pc)
    );

    assign bus.imem_pc  = pc_q;
    assign bus.id_valid = idValid;
    assign prog_done    = (state_q == S_END);
    assign fetch_fault  = (state_q == S_FAULT);

`ifdef FETCH_PERF_EN
    logic [31:0] perfFetch_q;
    logic [31:0] perfStall_q;

    // Both counters saturate rather than wrap so long runs stay meaningful.
    always_ff @(posedge clock) begin
        if (!reset) begin
            perfFetch_q <= 32'd0;
            perfStall_q <= 32'd0;
        end else begin
            if (loadIfid && perfFetch_q != 32'hFFFF_FFFF) begin
                perfFetch_q <= perfFetch_q + 32'd1;
            end
            if (state_q == S_RUN && idValid && !bus.id_ready &&
                perfStall_q != 32'hFFFF_FFFF) begin
                perfStall_q <= perfStall_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = perfFetch_q;
    assign perf_stall_cnt = perfStall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: boot, streaming, stalls,
// end of program, redirects (from stall and from END), misaligned fault and
// reset recovery. Perf counters are checked when FETCH_PERF_EN is defined.

module tb_fetch_unit;
    import riscv_fetch_pkg::*;

    logic clock;
    logic reset;
    logic progDone;
    logic fetchFault;
`ifdef FETCH_PERF_EN
    logic [31:0] perfFetchCnt;
    logic [31:0] perfStallCnt;
`endif

    int passCount  = 0;
    int totalCount = 0;

    fetch_unit_if fetchBus ();

    fetch_unit dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (fetchBus),
        .prog_done   (progDone),
        .fetch_fault (fetchFault)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perfFetchCnt),
        .perf_stall_cnt (perfStallCnt)
`endif
    );

    // Clock generation
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Instruction memory model: combinational read of a small program at 4..24
    logic [31:0] imem [0:7];
    initial begin
        imem[0] = NOP_INSTR;
        imem[1] = 32'h0094_0333;
        imem[2] = 32'h4129_83b3;
        imem[3] = 32'h00f7_68b3;
        imem[4] = 32'h00a0_0093;
        imem[5] = 32'h00b0_0113;
        imem[6] = 32'h01bd_2f33;
        imem[7] = 32'h0000_0000;
    end
    assign fetchBus.imem_instr = (fetchBus.imem_pc < 32'd32) ? imem[fetchBus.imem_pc[4:2]] : 32'h0;

    // Advance one cycle and settle 1 ns past the edge before sampling
    task automatic applyStimulus();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    initial begin
        reset = 1'b0;
        fetchBus.id_ready       = 1'b1;
        fetchBus.redirect_valid = 1'b0;
        fetchBus.redirect_pc    = 32'h0;

        // 1. reset and boot
        applyStimulus();
        applyStimulus();
        checkOutput("rst_valid",  {31'd0, fetchBus.id_valid}, 32'd0);
        checkOutput("rst_instr",  fetchBus.id_instr, 32'h0000_0013);
        checkOutput("rst_idpc",   fetchBus.id_pc, 32'd0);
        checkOutput("rst_pc",     fetchBus.imem_pc, 32'd4);
        checkOutput("rst_done",   {31'd0, progDone}, 32'd0);
        checkOutput("rst_fault",  {31'd0, fetchFault}, 32'd0);
        reset = 1'b1;
        applyStimulus();
        checkOutput("boot_valid", {31'd0, fetchBus.id_valid}, 32'd0);
        checkOutput("boot_pc",    fetchBus.imem_pc, 32'd4);
        applyStimulus();
        checkOutput("f4_instr",   fetchBus.id_instr, 32'h0094_0333);
        checkOutput("f4_idpc",    fetchBus.id_pc, 32'd4);
        checkOutput("f4_valid",   {31'd0, fetchBus.id_valid}, 32'd1);
        applyStimulus();
        checkOutput("f8_instr",   fetchBus.id_instr, 32'h4129_83b3);
        checkOutput("f8_pc",      fetchBus.imem_pc, 32'd12);

        // 2. three-cycle decode stall
        fetchBus.id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("stall_instr", fetchBus.id_instr, 32'h4129_83b3);
            checkOutput("stall_pc",    fetchBus.imem_pc, 32'd12);
        end
        fetchBus.id_ready = 1'b1;
        applyStimulus();
        checkOutput("rel_instr",  fetchBus.id_instr, 32'h00f7_68b3);
        checkOutput("rel_idpc",   fetchBus.id_pc, 32'd12);

        // 3. run to end of program
        applyStimulus();
        checkOutput("f16_instr",  fetchBus.id_instr, 32'h00a0_0093);
        applyStimulus();
        checkOutput("f20_instr",  fetchBus.id_instr, 32'h00b0_0113);
        applyStimulus();
        checkOutput("f24_instr",  fetchBus.id_instr, 32'h01bd_2f33);
        checkOutput("f24_idpc",   fetchBus.id_pc, 32'd24);
        checkOutput("f24_pc",     fetchBus.imem_pc, 32'd28);
        applyStimulus();
        checkOutput("end_done",   {31'd0, progDone}, 32'd1);
        checkOutput("end_valid",  {31'd0, fetchBus.id_valid}, 32'd0);
        checkOutput("end_pc",     fetchBus.imem_pc, 32'd28);
`ifdef FETCH_PERF_EN
        // 6. six fetches (pc 4..24) and three stall cycles
        checkOutput("perf_fetch", perfFetchCnt, 32'd6);
        checkOutput("perf_stall", perfStallCnt, 32'd3);
`endif
        applyStimulus();
        checkOutput("end_hold_pc", fetchBus.imem_pc, 32'd28);

        // 4a. redirect out of END clears prog_done
        fetchBus.redirect_valid = 1'b1;
        fetchBus.redirect_pc    = 32'd8;
        applyStimulus();
        fetchBus.redirect_valid = 1'b0;
        checkOutput("rdE_done",   {31'd0, progDone}, 32'd0);
        checkOutput("rdE_valid",  {31'd0, fetchBus.id_valid}, 32'd0);
        checkOutput("rdE_pc",     fetchBus.imem_pc, 32'd8);
        applyStimulus();
        checkOutput("rdE_instr",  fetchBus.id_instr, 32'h4129_83b3);
        checkOutput("rdE_idpc",   fetchBus.id_pc, 32'd8);

        // 4b. redirect during a stall flushes the held entry
        fetchBus.id_ready = 1'b0;
        applyStimulus();
        checkOutput("st2_valid",  {31'd0, fetchBus.id_valid}, 32'd1);
        fetchBus.redirect_valid = 1'b1;
        fetchBus.redirect_pc    = 32'd8;
        applyStimulus();
        fetchBus.redirect_valid = 1'b0;
        fetchBus.id_ready       = 1'b1;
        checkOutput("rdS_valid",  {31'd0, fetchBus.id_valid}, 32'd0);
        checkOutput("rdS_pc",     fetchBus.imem_pc, 32'd8);
        applyStimulus();
        checkOutput("rdS_instr",  fetchBus.id_instr, 32'h4129_83b3);
        checkOutput("rdS_idpc",   fetchBus.id_pc, 32'd8);
        checkOutput("rdS_valid2", {31'd0, fetchBus.id_valid}, 32'd1);

        // 5. misaligned redirect faults and freezes fetch
        fetchBus.redirect_valid = 1'b1;
        fetchBus.redirect_pc    = 32'h0000_000A;
        applyStimulus();
        fetchBus.redirect_valid = 1'b0;
        checkOutput("flt_fault",  {31'd0, fetchFault}, 32'd1);
        checkOutput("flt_valid",  {31'd0, fetchBus.id_valid}, 32'd0);
        checkOutput("flt_pc",     fetchBus.imem_pc, 32'd12);
        fetchBus.redirect_valid = 1'b1;
        fetchBus.redirect_pc    = 32'd4;
        applyStimulus();
        fetchBus.redirect_valid = 1'b0;
        applyStimulus();
        checkOutput("flt_hold_pc",    fetchBus.imem_pc, 32'd12);
        checkOutput("flt_hold_valid", {31'd0, fetchBus.id_valid}, 32'd0);
        checkOutput("flt_hold_fault", {31'd0, fetchFault}, 32'd1);

        // reset recovery, then a redirect that discards a same-cycle fetch
        reset = 1'b0;
        applyStimulus();
        checkOutput("rr_fault",   {31'd0, fetchFault}, 32'd0);
        checkOutput("rr_pc",      fetchBus.imem_pc, 32'd4);
        reset = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("rr_instr",   fetchBus.id_instr, 32'h0094_0333);
        fetchBus.redirect_valid = 1'b1;
        fetchBus.redirect_pc    = 32'd20;
        applyStimulus();
        fetchBus.redirect_valid = 1'b0;
        checkOutput("rdR_valid",  {31'd0, fetchBus.id_valid}, 32'd0);
        checkOutput("rdR_pc",     fetchBus.imem_pc, 32'd20);
        applyStimulus();
        checkOutput("rdR_instr",  fetchBus.id_instr, 32'h00b0_0113);
        checkOutput("rdR_idpc",   fetchBus.id_pc, 32'd20);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage of the single-issue RV32I core. Sits directly upstream of the instruction memory and drives its byte-address PC. Captures the returned 32-bit instruction word into an IF/ID pipeline register, which it presents to decode with a valid/ready handshake. Handles branch/jump redirects, decode stalls, end-of-program detection and misaligned-target faults.

Parameters:
RESET_PC, 32'h0000_0004, PC loaded on reset; the first program word sits at byte 4.
PC_LIMIT, 32'd28, first byte address past the program; fetch stops when PC >= PC_LIMIT.

Ports:
clock  input  1  core clock, all state updates on posedge
reset  input  1  synchronous, active-low reset
imem_pc  output  32  byte address to instruction memory (combinational read)
imem_instr  input  32  instruction word returned by memory for imem_pc, same cycle
redirect_valid  input  1  taken branch/jump from execute
redirect_pc  input  32  redirect target byte address
id_ready  input  1  decode accepts id_instr this cycle
id_valid  output  1  id_instr/id_pc hold a valid instruction
id_instr  output  32  fetched instruction word
id_pc  output  32  address of id_instr
prog_done  output  1  PC has reached PC_LIMIT; no further fetches
fetch_fault  output  1  sticky; a redirect target was misaligned

Behaviour:
- Reset (reset==0 at posedge): pc=RESET_PC, state=S_BOOT, id_valid=0, id_instr=32'h0000_0013 (NOP), id_pc=0, prog_done=0, fetch_fault=0. Reset mid-operation discards all in-flight state the same way.
- imem_pc = pc at all times, purely from the register.
- FSM states: S_BOOT, S_RUN, S_END, S_FAULT.
- S_BOOT: one idle cycle after reset release so memory initialisation completes. No fetch. Next state is S_RUN.
- S_RUN, fetch condition = !id_valid || id_ready.
  - If fetch is allowed: id_instr<=imem_instr, id_pc<=pc, id_valid<=1, pc<=pc+4.
  - If id_valid && !id_ready (stall): pc, id_instr, id_pc and id_valid all hold.
  - id_valid deasserts only when id_ready is high and no new fetch occurs.
- Latency: a PC presented in cycle N appears on id_instr in cycle N+1. Sustained throughput is one instruction per cycle while id_ready is held at 1.
- End of program: when pc >= PC_LIMIT in S_RUN, no fetch occurs and the next state is S_END. In S_END, prog_done=1. The last id_valid entry still drains normally through the handshake.
- Redirect has highest priority, in any state except S_BOOT and S_FAULT.
  - Effect: pc<=redirect_pc and id_valid<=0 (flush), even during a stall.
  - From S_END, the next state is S_RUN and prog_done clears if redirect_pc < PC_LIMIT. Otherwise the FSM stays in S_END.
  - If redirect_pc[1:0] != 0: fetch_fault<=1, id_valid<=0, pc is unchanged, next state S_FAULT.
- S_FAULT is terminal until reset. No fetches; id_valid=0.
- Redirect and fetch in the same cycle: the redirect wins and the fetched word is discarded.
- Arithmetic: pc+4 is 32-bit modulo 2^32. Wrap-around is not special-cased; PC_LIMIT stops fetch first.

Optional Feature:
Macro FETCH_PERF_EN.
- Defined: adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0], both zeroed on reset.
  - perf_fetch_cnt increments on each accepted fetch.
  - perf_stall_cnt increments each cycle in S_RUN with id_valid && !id_ready.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package riscv_fetch_pkg holds:
  - fetch state enum/localparams (S_BOOT..S_FAULT);
  - NOP_INSTR = 32'h0000_0013;
  - INSTR_BYTES = 4.
- One natural sub-module, ifid_reg: holds the valid/instr/pc register with load, hold and flush controls, driven by the fetch_unit FSM.

Test Plan:
1. Reset low for 2 cycles, then high, id_ready=1 → S_BOOT for 1 cycle; imem_pc=4. The next cycles show id_instr 0x00940333 (pc 4), 0x412983b3 (pc 8), 0x00f768b3 (pc 12), one per cycle.
2. id_ready=0 for 3 cycles after the pc-8 word → id_instr holds 0x412983b3 and imem_pc holds 12. On release, 0x00f768b3 follows the next cycle with no loss or duplicate.
3. Run to the end with id_ready=1 → the last word is 0x01bd2f33 at id_pc 24. imem_pc=28, prog_done=1, and id_valid drops the following cycle.
4. Redirect_valid with redirect_pc=8 during a stall → id_valid=0 the next cycle, then 0x412983b3 with id_pc=8. From S_END, the same redirect clears prog_done.
5. Redirect_pc=32'h0000_000A → fetch_fault=1, id_valid=0, no further fetches until reset; reset clears fetch_fault and restarts at pc 4.
6. With FETCH_PERF_EN: 6 fetches plus a 3-cycle stall → perf_fetch_cnt=6, perf_stall_cnt=3.
